wb_stage_buffer: RTL and testbench

WB_STAGE_BUFFER -- requirements
Module: wb_stage_buffer

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_entry_reg.sv | 17 +
 rtl/wb_stage_buffer.sv | 118 +++++++++++
 tb/tb_wb_stage_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage buffer.
package wb_pkg;

  localparam int WB_WIDTH_DEF = 32;
  localparam int WB_RA_W_DEF  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  // Payload is {PCSrc, RegWrite, MemtoReg, WA3, ALUOut, ReadData}.
  function automatic int wb_payload_w(input int width, input int ra_w);
    return 3 + ra_w + 2 * width;
  endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// One buffer slot: payload register with load enable and async active-low clear.
module wb_entry_reg #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/wb_stage_buffer.sv
// Two-entry in-order M->W stage buffer with valid/ready on both sides.
// Optional macro WB_STAGE_RESULT_EN adds the ResultW write-back mux output.
module wb_stage_buffer
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH_DEF,
  parameter int RA_W  = WB_RA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             PCSrcM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] ReadDataM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [RA_W-1:0]  WA3W,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [1:0]       occupancy,
  output wb_state_e        state_dbg
`ifdef WB_STAGE_RESULT_EN
  ,
  output logic [WIDTH-1:0] ResultW
`endif
);

  localparam int PW = wb_payload_w(WIDTH, RA_W);

  wb_state_e     state_q, state_d;
  logic          push, pop;
  logic          head_load, tail_load, head_sel_tail;
  logic [PW-1:0] in_pl, head_d, head_q, tail_q, w_pl;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; flush cancels any transfer in the same cycle on either side.
  assign in_ready  = (state_q != FULL) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign in_pl  = {PCSrcM, RegWriteM, MemtoRegM, WA3M, ALUOutM, ReadDataM};
  assign head_d = head_sel_tail ? tail_q : in_pl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    head_load     = 1'b0;
    tail_load     = 1'b0;
    head_sel_tail = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d   = HALF;
          head_load = 1'b1;
        end
        HALF: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            tail_load = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d       = HALF;
          head_load     = 1'b1;
          head_sel_tail = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  wb_entry_reg #(.W(PW)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  wb_entry_reg #(.W(PW)) u_tail (
    .clk   (clk),
    .reset (reset),
    .load  (tail_load),
    .d     (in_pl),
    .q     (tail_q)
  );

  // Gating on out_valid keeps stale slot contents from leaking into W.
  assign w_pl = out_valid ? head_q : '0;
  assign {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW} = w_pl;

  assign occupancy = (state_q == FULL) ? 2'd2 : (state_q == HALF) ? 2'd1 : 2'd0;
  assign state_dbg = state_q;

`ifdef WB_STAGE_RESULT_EN
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
`endif

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Self-checking bench for wb_stage_buffer: queue-based reference model plus
// directed literal checks and a randomized traffic phase.
module tb_wb_stage_buffer;

  localparam int WIDTH = 32;
  localparam int RA_W  = 4;
  localparam int PW    = 3 + RA_W + 2 * WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [PW-1:0]    in_pl = '0;
  logic             in_ready, out_valid;
  logic             PCSrcM, RegWriteM, MemtoRegM;
  logic [RA_W-1:0]  WA3M;
  logic [WIDTH-1:0] ALUOutM, ReadDataM;
  logic             PCSrcW, RegWriteW, MemtoRegW;
  logic [RA_W-1:0]  WA3W;
  logic [WIDTH-1:0] ALUOutW, ReadDataW;
  logic [1:0]       occupancy;
  logic [1:0]       state_dbg;
`ifdef WB_STAGE_RESULT_EN
  logic [WIDTH-1:0] ResultW;
`endif
  logic [PW-1:0]    act_pl;

  logic [PW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {PCSrcM, RegWriteM, MemtoRegM, WA3M, ALUOutM, ReadDataM} = in_pl;
  assign act_pl = {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW};

  wb_stage_buffer #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .PCSrcM    (PCSrcM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .WA3M      (WA3M),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .PCSrcW    (PCSrcW),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .WA3W      (WA3W),
    .ALUOutW   (ALUOutW),
    .ReadDataW (ReadDataW),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
`ifdef WB_STAGE_RESULT_EN
    ,
    .ResultW   (ResultW)
`endif
  );

  function automatic logic [PW-1:0] mk(input logic pc, input logic rw, input logic mtr,
                                       input logic [RA_W-1:0] wa, input logic [WIDTH-1:0] alu,
                                       input logic [WIDTH-1:0] rd);
    return {pc, rw, mtr, wa, alu, rd};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every visible output against the model's view of the buffer.
  task automatic check_model();
    logic [PW-1:0]    head;
    logic [WIDTH-1:0] res;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    res  = head[2*WIDTH+RA_W] ? head[WIDTH-1:0] : head[2*WIDTH-1:WIDTH];
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    check("occupancy", 128'(occupancy), 128'(exp_q.size()));
    check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2 && !flush));
    check("w_payload", 128'(act_pl), 128'(head));
`ifdef WB_STAGE_RESULT_EN
    check("result_w", 128'(ResultW), 128'(res));
`else
    if (res !== res) check("result_unused", 128'(res), 128'(res));
`endif
  endtask

  // One clock: check current outputs, then apply the edge to the model.
  task automatic tick();
    bit push, pop;
    #1;
    check_model();
    push = in_valid && (exp_q.size() < 2) && !flush;
    pop  = (exp_q.size() > 0) && out_ready && !flush;
    @(posedge clk);
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_pl);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [PW-1:0] pl);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_pl     = pl;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_occ"}, 128'(occupancy), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_w_zero"}, 128'(act_pl), 128'(0));
`ifdef WB_STAGE_RESULT_EN
    check({tag, "_result_zero"}, 128'(ResultW), 128'(0));
`endif
  endtask

  initial begin
    logic [95:0] r;

    // Reset held low for two cycles with benign inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset");

    // Single push then drain.
    drive(1, 1, 0, mk(0, 1, 1, 4'h5, 32'h0000_1000, 32'hDEAD_BEEF));
    tick();
    drive(0, 1, 0, '0);
    check("single_valid", 128'(out_valid), 128'(1));
    check("single_wa3", 128'(WA3W), 128'(4'h5));
    check("single_rd", 128'(ReadDataW), 128'(32'hDEAD_BEEF));
    check("single_rw", 128'(RegWriteW), 128'(1));
    tick();
    check("single_drained", 128'(out_valid), 128'(0));

    // Fill to FULL with backpressure; third offer must be refused.
    drive(1, 0, 0, mk(0, 1, 0, 4'h1, 32'd1, 32'h0));
    tick();
    drive(1, 0, 0, mk(0, 1, 0, 4'h2, 32'd2, 32'h0));
    tick();
    drive(1, 0, 0, mk(0, 1, 0, 4'h3, 32'd3, 32'h0));
    #1;
    check("full_occ", 128'(occupancy), 128'(2));
    check("full_in_ready", 128'(in_ready), 128'(0));
    tick();
    drive(0, 1, 0, '0);
    check("order_a", 128'(ALUOutW), 128'(1));
    tick();
    check("order_b", 128'(ALUOutW), 128'(2));
    tick();
    check("order_empty", 128'(out_valid), 128'(0));

    // Flush from FULL while both sides try to transfer.
    drive(1, 0, 0, mk(1, 1, 0, 4'h7, 32'd10, 32'd0));
    tick();
    tick();
    drive(1, 1, 1, mk(1, 1, 0, 4'h8, 32'd11, 32'd0));
    tick();
    drive(0, 0, 0, '0);
    check("flush_occ", 128'(occupancy), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_rw", 128'(RegWriteW), 128'(0));
    tick();
    check("flush_not_stored", 128'(out_valid), 128'(0));

    // Steady HALF streaming: head trails input by one cycle.
    drive(1, 0, 0, mk(0, 1, 0, 4'h0, 32'd0, 32'd0));
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, mk(0, 1, 0, 4'(i), 32'(i), 32'd0));
      tick();
      check("stream_alu", 128'(ALUOutW), 128'(i));
      check("stream_occ", 128'(occupancy), 128'(1));
    end
    drive(0, 1, 0, '0);
    tick();

    // Result mux selection and asynchronous reset while FULL.
    drive(1, 0, 0, mk(0, 1, 1, 4'h9, 32'h11, 32'hAA));
    tick();
    check("mtr1_rd", 128'(ReadDataW), 128'(32'hAA));
`ifdef WB_STAGE_RESULT_EN
    check("mtr1_result", 128'(ResultW), 128'(32'hAA));
`endif
    drive(1, 0, 0, mk(0, 1, 0, 4'hA, 32'h22, 32'hBB));
    tick();
    drive(0, 1, 0, '0);
    tick();
    check("mtr0_alu", 128'(ALUOutW), 128'(32'h22));
`ifdef WB_STAGE_RESULT_EN
    check("mtr0_result", 128'(ResultW), 128'(32'h22));
`endif
    drive(1, 0, 0, mk(1, 1, 1, 4'hB, 32'h33, 32'hCC));
    tick();
    drive(0, 0, 0, '0);
    check("pre_reset_occ", 128'(occupancy), 128'(2));
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, mk(0, 1, 0, 4'hC, 32'h44, 32'hDD));
    tick();
    check("post_reset_head", 128'(ALUOutW), 128'(32'h44));
    check("post_reset_occ", 128'(occupancy), 128'(1));

    // Randomized traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      r = {$urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), r[PW-1:0]);
      tick();
    end
    drive(0, 1, 0, '0);
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
